// File: rtl/mips_defs_pkg.sv
// Shared opcode, funct, ALU and select encodings for the multi-cycle MIPS control path.
package mips_defs;

    // Opcodes (IR[31:26])
    localparam logic [5:0] R_type = 6'b000000;
    localparam logic [5:0] Ori    = 6'b001101;
    localparam logic [5:0] Lw     = 6'b100011;
    localparam logic [5:0] Sw     = 6'b101011;
    localparam logic [5:0] Beq    = 6'b000100;
    localparam logic [5:0] Lui    = 6'b001111;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] Jal    = 6'b000011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] Add    = 6'b100000;
    localparam logic [5:0] Sub    = 6'b100010;
    localparam logic [5:0] Jr_    = 6'b001000;
    localparam logic [5:0] Sll    = 6'b000000;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SHIFT = 4'b0110;

    // Sequencer states; codes 5..7 are unused and recover to StIf
    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_t;

    // PC source select
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // Register destination select
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_LINK = 2'd2;

    // Write-back data select
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MDR  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decode feeding the sequencer.
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       is_rtype_alu,
    output logic       is_jr,
    output logic       is_imm_alu,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_link,
    output logic       is_illegal
);

    // Classify the opcode/funct pair; anything unrecognised retires as a nop
    always_comb begin
        is_rtype_alu = (op == R_type) && ((funct == Add) || (funct == Sub) || (funct == Sll));
        is_jr        = (op == R_type) && (funct == Jr_);
        is_imm_alu   = (op == Ori) || (op == Lui);
        is_load      = (op == Lw);
        is_store     = (op == Sw);
        is_branch    = (op == Beq);
        is_jump      = (op == J) || (op == Jal);
        is_link      = (op == Jal);
        is_illegal   = !(is_rtype_alu || is_jr || is_imm_alu || is_load || is_store ||
                         is_branch || is_jump);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: IF/ID/EX/MEM/WB with memory-ready stalls and retire counter.
module mc_ctrl
    import mips_defs::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrcB,
    output logic             ExtOp,
    output logic [3:0]       ALUOp,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    // The datapath maps RegDst=DST_LINK to LINK_REG; writes to $0 would be silently dropped.
    if (LINK_REG == 5'd0) begin : g_link_reg_is_zero
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;

    logic is_rtype_alu, is_jr, is_imm_alu, is_load, is_store;
    logic is_branch, is_jump, is_link, is_illegal;

    mc_decode u_decode (
        .op           (OP),
        .funct        (Funct),
        .is_rtype_alu (is_rtype_alu),
        .is_jr        (is_jr),
        .is_imm_alu   (is_imm_alu),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_branch    (is_branch),
        .is_jump      (is_jump),
        .is_link      (is_link),
        .is_illegal   (is_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIf;
        else       state_q <= state_d;
    end

    // Next state and per-cycle strobes; everything held at zero while reset is high
    always_comb begin
        state_d    = state_q;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = PC_PLUS4;
        RegWrite   = 1'b0;
        RegDst     = DST_RT;
        MemtoReg   = WB_ALU;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUSrcB    = 1'b0;
        ExtOp      = 1'b0;
        ALUOp      = ALU_ADD;
        instr_done = 1'b0;
        if (reset) begin
            state_d = StIf;
        end else begin
            case (state_q)
                StIf: begin
                    if (imem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = StId;
                    end
                end
                StId: begin
                    if (is_jump) begin
                        PCWrite    = 1'b1;
                        PCSrc      = PC_JUMP;
                        instr_done = 1'b1;
                        state_d    = StIf;
                        if (is_link) begin
                            RegWrite = 1'b1;
                            RegDst   = DST_LINK;
                            MemtoReg = WB_LINK;
                        end
                    end else if (is_jr) begin
                        PCWrite    = 1'b1;
                        PCSrc      = PC_REG;
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end else if (is_illegal) begin
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end else begin
                        state_d = StEx;
                    end
                end
                StEx: begin
                    if (is_branch) begin
                        ALUOp      = ALU_SUB;
                        ExtOp      = 1'b1;
                        PCWrite    = Zero;
                        PCSrc      = Zero ? PC_BRANCH : PC_PLUS4;
                        instr_done = 1'b1;
                        state_d    = StIf;
                    end else if (is_rtype_alu) begin
                        case (Funct)
                            Sub:     ALUOp = ALU_SUB;
                            Sll:     ALUOp = ALU_SHIFT;
                            default: ALUOp = ALU_ADD;
                        endcase
                        state_d = StWb;
                    end else if (is_imm_alu) begin
                        ALUSrcB = 1'b1;
                        ALUOp   = (OP == Ori) ? ALU_OR : ALU_SHIFT;
                        state_d = StWb;
                    end else if (is_load || is_store) begin
                        ALUSrcB = 1'b1;
                        ExtOp   = 1'b1;
                        state_d = StMem;
                    end else begin
                        state_d = StIf;
                    end
                end
                StMem: begin
                    MemRead  = is_load;
                    MemWrite = is_store;
                    if (!(is_load || is_store)) begin
                        state_d = StIf;
                    end else if (dmem_ready) begin
                        instr_done = is_store;
                        state_d    = is_load ? StWb : StIf;
                    end
                end
                StWb: begin
                    RegWrite   = 1'b1;
                    RegDst     = is_rtype_alu ? DST_RD : DST_RT;
                    MemtoReg   = is_load ? WB_MDR : WB_ALU;
                    instr_done = 1'b1;
                    state_d    = StIf;
                end
                default: state_d = StIf;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           retired_q <= '0;
        else if (instr_done) retired_q <= retired_q + CNT_W'(1);
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle decode with a registered state machine (IF/ID/EX/MEM/WB). Each cycle it drives the datapath strobes and mux selects, and it stalls on instruction-memory and data-memory ready handshakes. It supports the same subset as the single-cycle decode: add, sub, sll, jr, ori, lw, sw, beq, lui, j, jal. It also counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
LINK_REG, 5'd31, register index written by jal

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
OP  in  6  opcode from instruction register (IR[31:26])
Funct  in  6  function field from instruction register (IR[5:0])
Zero  in  1  ALU zero flag (beq compare)
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
IRWrite  out  1  load IR; PC+4 computed
PCWrite  out  1  unconditional PC update
PCSrc  out  2  0=PC+4, 1=branch target, 2=jump target, 3=GPR[rs] (jr)
RegWrite  out  1  GPR write enable
RegDst  out  2  0=rt, 1=rd, 2=LINK_REG
MemtoReg  out  2  0=ALU result, 1=MDR, 2=PC+4 (link)
MemRead  out  1  data read request
MemWrite  out  1  data write request
ALUSrcB  out  1  0=GPR[rt], 1=extended immediate
ExtOp  out  1  1=sign-extend, 0=zero-extend
ALUOp  out  4  0000 add, 0001 sub, 0011 or, 0110 shift/lui
state  out  3  current state (debug)
instr_done  out  1  one-cycle pulse when an instruction retires
retired  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset: state=IF, retired=0. Every strobe (IRWrite, PCWrite, RegWrite, MemRead, MemWrite, instr_done) is forced 0 while reset is high. Select outputs are 0.
- State is registered. Outputs are combinational from state, OP, Funct, Zero and the ready inputs. OP and Funct are stable from ID until the next IF.
- Encodings: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5–7 are illegal and return to IF next cycle with no strobes.
- IF: hold until imem_ready. On the ready cycle, IRWrite=1, PCWrite=1, PCSrc=0, then go to ID.
- ID (decode):
  - j: PCWrite=1, PCSrc=2, retire, then IF.
  - jal: also RegWrite=1, RegDst=2, MemtoReg=2, retire, then IF.
  - jr (OP=0, Funct=001000): PCWrite=1, PCSrc=3, retire, then IF.
  - Unsupported OP/Funct: retire as nop, then IF.
  - All other instructions go to EX.
- EX:
  - beq: ALUOp=0001, ALUSrcB=0, ExtOp=1. If Zero, PCWrite=1 and PCSrc=1. Retire, then IF.
  - R-type add/sub/sll: ALUOp 0000/0001/0110, then WB.
  - ori: ALUSrcB=1, ExtOp=0, ALUOp=0011, then WB.
  - lui: ALUSrcB=1, ALUOp=0110, then WB.
  - lw/sw: ALUSrcB=1, ExtOp=1, ALUOp=0000, then MEM.
- MEM: MemRead (lw) or MemWrite (sw) stays asserted until dmem_ready.
  - lw with dmem_ready: go to WB.
  - sw with dmem_ready: retire, then IF.
  - Without dmem_ready: stay in MEM, request held, no other strobes.
- WB: RegWrite=1, retire, then IF.
  - R-type: RegDst=1, MemtoReg=0.
  - ori/lui: RegDst=0, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
- Retire: instr_done=1 for exactly that cycle; retired increments by 1 and wraps modulo 2^CNT_W.
- Latency with ready held high: j/jal/jr/nop 2 cycles, beq 3, R-type/ori/lui/sw 4, lw 5. Each wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to IF; no partial write completes after reset rises.
- A ready input arriving outside its waiting state is ignored.

Decomposition:
- Shared package mips_defs:
  - opcode and funct localparams (R_type, Ori, Lw, Sw, Beq, Lui, J, Jal; Add, Sub, Jr_, Sll)
  - ALUOp codes
  - state encodings
  - PCSrc, RegDst and MemtoReg select codes
- One natural sub-module, mc_decode: purely combinational instruction-class decode (is_rtype_alu, is_jr, is_imm_alu, is_load, is_store, is_branch, is_jump, is_link, is_illegal). The FSM consumes these flags.

Test Plan:
1. add with ready high, then reset release → states IF,ID,EX,WB; RegWrite=1 and RegDst=1 in cycle 4; instr_done once; retired=1.
2. lw with dmem_ready low for 3 cycles → MemRead high for 4 consecutive MEM cycles; WB has MemtoReg=1; total 8 cycles; no RegWrite before WB.
3. beq, once with Zero=1 and once with Zero=0 → 3 cycles each; PCWrite=1 with PCSrc=1 only when Zero=1; two retires.
4. jal → ID cycle: PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2; next state IF.
5. imem_ready low for 5 cycles, then sw → no IRWrite until ready; MemWrite held until dmem_ready; retired increments once.
6. reset pulsed while in MEM of sw → state=IF immediately; MemWrite=0 the same cycle; retired=0. Separately, retired=2^CNT_W−1 plus one retire → wraps to 0.
